// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcodes and sequencer state encoding for the calculator datapath.
package calc_pkg;

    localparam int MAX_MAG_DEF = 999;

    localparam logic [4:0] KEY_ADD = 5'd10;
    localparam logic [4:0] KEY_SUB = 5'd11;
    localparam logic [4:0] KEY_MUL = 5'd12;
    localparam logic [4:0] KEY_DIV = 5'd13;
    localparam logic [4:0] KEY_EQ  = 5'd14;
    localparam logic [4:0] KEY_CLR = 5'd15;
    localparam logic [4:0] KEY_NEG = 5'd16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_STROBE,
        ST_WAIT,
        ST_CAPTURE,
        ST_SHOW,
        ST_ERROR
    } state_t;

    function automatic logic is_digit(input logic [4:0] k);
        return k <= 5'd9;
    endfunction

    function automatic logic is_oper(input logic [4:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    // Operator keys are contiguous and ordered like the ALU opcodes.
    function automatic logic [1:0] key_to_op(input logic [4:0] k);
        return 2'(k - KEY_ADD);
    endfunction

endpackage

// File: rtl/operand_accum.sv
// One calculator operand: sign-magnitude entry register with digit append, negate and load.
module operand_accum
    import calc_pkg::*;
#(
    parameter int MAX_MAG = MAX_MAG_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr,
    input  logic               digit_en,
    input  logic [3:0]         digit,
    input  logic               neg_en,
    input  logic               load_en,
    input  logic [9:0]         load_mag,
    input  logic               load_neg,
    output logic signed [10:0] value,
    output logic               has_digit
);

    logic [9:0]         mag;
    logic               sign;
    logic [9:0]         base_mag;
    logic [13:0]        appended;
    logic signed [10:0] mag_s;

    // A digit arriving with clr starts a fresh operand rather than extending the old one.
    always_comb begin
        base_mag = clr ? 10'd0 : mag;
        appended = ({4'd0, base_mag} << 3) + ({4'd0, base_mag} << 1) + {10'd0, digit};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag       <= '0;
            sign      <= 1'b0;
            has_digit <= 1'b0;
        end else if (load_en) begin
            mag       <= load_mag;
            sign      <= load_neg && (load_mag != 10'd0);
            has_digit <= 1'b1;
        end else if (digit_en) begin
            has_digit <= 1'b1;
            if (clr)
                sign <= 1'b0;
            if (appended <= 14'(MAX_MAG))
                mag <= appended[9:0];
        end else if (clr) begin
            mag       <= '0;
            sign      <= 1'b0;
            has_digit <= 1'b0;
        end else if (neg_en && (mag != 10'd0)) begin
            sign <= ~sign;
        end
    end

    assign mag_s = {1'b0, mag};
    assign value = sign ? -mag_s : mag_s;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-to-ALU controller: operand entry, opcode latch, ALU strobe/capture and display drive.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_MAG = MAX_MAG_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [4:0]         key_code,
    output logic signed [10:0] alu_a,
    output logic signed [10:0] alu_b,
    output logic [1:0]         alu_opcode,
    output logic               alu_strobe,
    input  logic signed [20:0] alu_result,
    input  logic               alu_remain,
    input  logic [20:0]        alu_remainder,
    output logic signed [20:0] disp_value,
    output logic               disp_remain,
    output logic [20:0]        disp_remainder,
    output logic [1:0]         disp_mode,
    output logic               busy
);

    state_t             state, state_nxt;
    logic               key_armed;
    logic               key;
    logic [7:0]         wait_cnt;
    logic [1:0]         opcode;
    logic signed [20:0] res_q;
    logic               rem_q;
    logic [20:0]        remainder_q;
    logic [20:0]        res_abs;

    logic a_clr, a_dig, a_neg, a_load, a_has;
    logic b_clr, b_dig, b_neg, b_has;
    logic cur_has;
    logic op_load, cap_en, cap_clr;
    logic [1:0] op_val;

    operand_accum #(.MAX_MAG(MAX_MAG)) u_opa (
        .clock     (clock),
        .reset     (reset),
        .clr       (a_clr),
        .digit_en  (a_dig),
        .digit     (key_code[3:0]),
        .neg_en    (a_neg),
        .load_en   (a_load),
        .load_mag  (res_abs[9:0]),
        .load_neg  (res_q[20]),
        .value     (alu_a),
        .has_digit (a_has)
    );

    operand_accum #(.MAX_MAG(MAX_MAG)) u_opb (
        .clock     (clock),
        .reset     (reset),
        .clr       (b_clr),
        .digit_en  (b_dig),
        .digit     (key_code[3:0]),
        .neg_en    (b_neg),
        .load_en   (1'b0),
        .load_mag  (10'd0),
        .load_neg  (1'b0),
        .value     (alu_b),
        .has_digit (b_has)
    );

    assign busy       = (state == ST_STROBE) || (state == ST_WAIT) || (state == ST_CAPTURE);
    assign alu_strobe = (state == ST_STROBE);
    assign alu_opcode = opcode;
    // key_armed keeps a key that coincides with reset release from being acted on.
    assign key        = key_valid && key_armed;
    assign res_abs    = res_q[20] ? (~res_q + 21'd1) : res_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_ENTER_A;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        a_clr     = 1'b0;
        a_dig     = 1'b0;
        a_neg     = 1'b0;
        a_load    = 1'b0;
        b_clr     = 1'b0;
        b_dig     = 1'b0;
        b_neg     = 1'b0;
        op_load   = 1'b0;
        op_val    = key_to_op(key_code);
        cap_en    = 1'b0;
        cap_clr   = 1'b0;
        cur_has   = (state == ST_ENTER_B) ? b_has : a_has;
        if (key && (key_code == KEY_CLR) && !busy) begin
            a_clr     = 1'b1;
            b_clr     = 1'b1;
            op_load   = 1'b1;
            op_val    = OP_ADD;
            cap_clr   = 1'b1;
            state_nxt = ST_ENTER_A;
        end else begin
            case (state)
                ST_ENTER_A: if (key) begin
                    if (is_digit(key_code))
                        a_dig = 1'b1;
                    else if (key_code == KEY_NEG)
                        a_neg = 1'b1;
                    else if (is_oper(key_code)) begin
                        op_load   = 1'b1;
                        b_clr     = 1'b1;
                        state_nxt = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: if (key) begin
                    if (is_digit(key_code))
                        b_dig = 1'b1;
                    else if (key_code == KEY_NEG)
                        b_neg = 1'b1;
                    else if (is_oper(key_code) && !cur_has)
                        op_load = 1'b1;
                    else if ((key_code == KEY_EQ) && cur_has)
                        state_nxt = ((opcode == OP_DIV) && (alu_b == 11'sd0)) ? ST_ERROR : ST_STROBE;
                end
                ST_STROBE:  state_nxt = ST_WAIT;
                ST_WAIT:    if (wait_cnt == 8'(ALU_LAT - 1)) state_nxt = ST_CAPTURE;
                ST_CAPTURE: begin
                    cap_en    = 1'b1;
                    state_nxt = ST_SHOW;
                end
                ST_SHOW: if (key) begin
                    if (is_digit(key_code)) begin
                        a_clr     = 1'b1;
                        a_dig     = 1'b1;
                        state_nxt = ST_ENTER_A;
                    end else if (is_oper(key_code)) begin
                        if (res_abs <= 21'(MAX_MAG)) begin
                            a_load    = 1'b1;
                            op_load   = 1'b1;
                            b_clr     = 1'b1;
                            state_nxt = ST_ENTER_B;
                        end else begin
                            state_nxt = ST_ERROR;
                        end
                    end
                end
                ST_ERROR: ;
                default:  state_nxt = ST_ENTER_A;
            endcase
        end
    end

    // Remainder is only meaningful for division, so it is masked at capture time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_armed   <= 1'b0;
            wait_cnt    <= '0;
            opcode      <= OP_ADD;
            res_q       <= '0;
            rem_q       <= 1'b0;
            remainder_q <= '0;
        end else begin
            key_armed <= 1'b1;
            wait_cnt  <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (op_load)
                opcode <= op_val;
            if (cap_clr) begin
                res_q       <= '0;
                rem_q       <= 1'b0;
                remainder_q <= '0;
            end else if (cap_en) begin
                res_q       <= alu_result;
                rem_q       <= alu_remain && (opcode == OP_DIV);
                remainder_q <= (opcode == OP_DIV) ? alu_remainder : 21'd0;
            end
        end
    end

    always_comb begin
        disp_mode      = 2'd0;
        disp_value     = '0;
        disp_remain    = 1'b0;
        disp_remainder = '0;
        case (state)
            ST_ENTER_A: disp_value = {{10{alu_a[10]}}, alu_a};
            ST_SHOW: begin
                disp_mode      = 2'd2;
                disp_value     = res_q;
                disp_remain    = rem_q;
                disp_remainder = remainder_q;
            end
            ST_ERROR: disp_mode = 2'd3;
            default: begin
                disp_mode  = 2'd1;
                disp_value = {{10{alu_b[10]}}, alu_b};
            end
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural calculator model and an ALU stand-in.
module tb_calc_sequencer;

    logic               clock;
    logic               reset;
    logic               key_valid;
    logic [4:0]         key_code;
    logic signed [10:0] alu_a, alu_b;
    logic [1:0]         alu_opcode;
    logic               alu_strobe;
    logic signed [20:0] alu_result;
    logic               alu_remain;
    logic [20:0]        alu_remainder;
    logic signed [20:0] disp_value;
    logic               disp_remain;
    logic [20:0]        disp_remainder;
    logic [1:0]         disp_mode;
    logic               busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    int n_strobe = 0;
    int exp_strobe = 0;

    int m_mode, m_a, m_b, m_op, m_res, m_rem;
    bit m_bdig;

    calc_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_opcode     (alu_opcode),
        .alu_strobe     (alu_strobe),
        .alu_result     (alu_result),
        .alu_remain     (alu_remain),
        .alu_remainder  (alu_remainder),
        .disp_value     (disp_value),
        .disp_remain    (disp_remain),
        .disp_remainder (disp_remainder),
        .disp_mode      (disp_mode),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Floor division with non-negative remainder magnitude, as the ALU does.
    function automatic int fdiv(int a, int b);
        int q;
        if (b == 0) return 0;
        q = a / b;
        if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int alu_res(int a, int b, int op);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a * b;
            default: return fdiv(a, b);
        endcase
    endfunction

    // Non-divide ops return a junk remainder so display masking is exercised.
    function automatic int alu_rem(int a, int b, int op);
        int r;
        if (op != 3) return 7;
        r = a - fdiv(a, b) * b;
        return (r < 0) ? -r : r;
    endfunction

    assign alu_result    = 21'(alu_res(int'(alu_a), int'(alu_b), int'(alu_opcode)));
    assign alu_remainder = 21'(alu_rem(int'(alu_a), int'(alu_b), int'(alu_opcode)));
    assign alu_remain    = (alu_rem(int'(alu_a), int'(alu_b), int'(alu_opcode)) != 0);

    always @(posedge clock) if (alu_strobe) n_strobe <= n_strobe + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int append(int v, int d);
        int m;
        int n;
        m = (v < 0) ? -v : v;
        n = m * 10 + d;
        if (n > 999) return v;
        return (v < 0) ? -n : n;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_rem = 0; m_bdig = 0;
    endtask

    task automatic model_key(input int k);
        bit dig;
        bit op;
        int ra;
        dig = (k <= 9);
        op  = (k >= 10 && k <= 13);
        ra  = (m_res < 0) ? -m_res : m_res;
        if (k == 15) model_clear();
        else case (m_mode)
            0: begin
                if (dig) m_a = append(m_a, k);
                else if (k == 16) m_a = -m_a;
                else if (op) begin m_op = k - 10; m_b = 0; m_bdig = 0; m_mode = 1; end
            end
            1: begin
                if (dig) begin m_b = append(m_b, k); m_bdig = 1; end
                else if (k == 16) m_b = -m_b;
                else if (op && !m_bdig) m_op = k - 10;
                else if (k == 14 && m_bdig && m_op == 3 && m_b == 0) m_mode = 3;
            end
            2: begin
                if (dig) begin m_a = k; m_mode = 0; end
                else if (op) begin
                    if (ra <= 999) begin m_a = m_res; m_op = k - 10; m_b = 0; m_bdig = 0; m_mode = 1; end
                    else m_mode = 3;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        int ev;
        bit div_show;
        ev = (m_mode == 0) ? m_a : (m_mode == 1) ? m_b : (m_mode == 2) ? m_res : 0;
        div_show = (m_mode == 2) && (m_op == 3);
        chk("disp_mode", int'(disp_mode), m_mode);
        chk("disp_value", int'(disp_value), ev);
        chk("alu_a", int'(alu_a), m_a);
        chk("alu_b", int'(alu_b), m_b);
        chk("alu_opcode", int'(alu_opcode), m_op);
        chk("busy_idle", int'(busy), 0);
        chk("strobe_idle", int'(alu_strobe), 0);
        chk("disp_remain", int'(disp_remain), (div_show && m_rem != 0) ? 1 : 0);
        chk("disp_remainder", int'(disp_remainder), div_show ? m_rem : 0);
    endtask

    always @(posedge clock) begin
        #1;
        if (chk_en) check_model();
    end

    // '=' that launches an operation; optionally hammers keys (incl. clear) while busy.
    task automatic go(input bit inject);
        chk_en = 0;
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = 5'd14;
        @(posedge clock); #1;
        key_valid = inject;
        key_code  = 5'd15;
        exp_strobe++;
        chk("strobe_hi", int'(alu_strobe), 1);
        chk("busy_strobe", int'(busy), 1);
        chk("strobe_a", int'(alu_a), m_a);
        chk("strobe_b", int'(alu_b), m_b);
        chk("strobe_op", int'(alu_opcode), m_op);
        for (int c = 2; c <= 3; c++) begin
            @(posedge clock); #1;
            key_code = (c == 2) ? 5'd3 : 5'd10;
            chk("strobe_lo", int'(alu_strobe), 0);
            chk("busy_hold", int'(busy), 1);
            chk("hold_a", int'(alu_a), m_a);
            chk("hold_b", int'(alu_b), m_b);
            chk("hold_op", int'(alu_opcode), m_op);
            chk("no_early_result", int'(disp_mode == 2'd2), 0);
        end
        @(posedge clock); #1;
        key_valid = 1'b0;
        m_res  = alu_res(m_a, m_b, m_op);
        m_rem  = alu_rem(m_a, m_b, m_op);
        m_mode = 2;
        chk("result_mode", int'(disp_mode), 2);
        chk("result_busy", int'(busy), 0);
        chk_en = 1;
    endtask

    task automatic press(input int k, input bit inject = 1'b0);
        if (m_mode == 1 && k == 14 && m_bdig && !(m_op == 3 && m_b == 0)) begin
            go(inject);
        end else begin
            @(negedge clock);
            key_valid = 1'b1;
            key_code  = 5'(k);
            @(posedge clock);
            model_key(k);
            @(negedge clock);
            key_valid = 1'b0;
        end
    endtask

    task automatic keys(input int seq[$]);
        foreach (seq[i]) press(seq[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] raw;
        reset = 1'b1; key_valid = 1'b0; key_code = 5'd0;
        model_clear();
        #2;
        chk("rst_disp_value", int'(disp_value), 0);
        chk("rst_disp_mode", int'(disp_mode), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_opcode", int'(alu_opcode), 0);
        chk("rst_strobe", int'(alu_strobe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_remain", int'(disp_remain), 0);
        chk("rst_remainder", int'(disp_remainder), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk_en = 1;

        keys('{1, 2, 3, 10, 4, 5});
        press(14, 1'b1);
        chk("sum_168", int'(disp_value), 168);

        keys('{15, 9, 9, 9, 9});
        chk("a_999", int'(alu_a), 999);
        press(16);
        raw = alu_a;
        chk("a_neg999_raw", int'(raw), 32'h419);

        keys('{15, 7, 13, 0, 14});
        chk("div0_mode", int'(disp_mode), 3);
        chk("div0_value", int'(disp_value), 0);
        chk("div0_nostrobe", n_strobe, exp_strobe);
        keys('{9, 16, 14, 10});
        chk("error_sticky", int'(disp_mode), 3);
        press(15);
        chk("clr_mode", int'(disp_mode), 0);
        chk("clr_value", int'(disp_value), 0);
        chk("clr_remain", int'(disp_remain), 0);

        keys('{7, 16, 13, 2, 14});
        chk("div_q", int'(disp_value), -4);
        chk("div_remflag", int'(disp_remain), 1);
        chk("div_rem", int'(disp_remainder), 1);

        keys('{15, 5, 12, 6, 14, 10});
        chk("chain_a", int'(alu_a), 30);
        keys('{4, 14});
        chk("chain_34", int'(disp_value), 34);
        chk("chain_noremain", int'(disp_remain), 0);

        keys('{15, 9, 9, 9, 12, 9, 9, 9, 14});
        chk("prod", int'(disp_value), 998001);
        press(10);
        chk("ovf_error", int'(disp_mode), 3);

        keys('{15, 8, 10, 11, 3, 14});
        chk("op_replace", int'(disp_value), 5);

        keys('{15, 14, 2, 12, 3, 10, 14});
        chk("op_ignored", int'(disp_value), 6);
        press(4);
        chk("show_digit_mode", int'(disp_mode), 0);
        chk("show_digit_a", int'(alu_a), 4);

        keys('{15, 16, 4});
        chk("neg_zero", int'(alu_a), 4);
        press(16);
        chk("neg_four", int'(alu_a), -4);

        // Reset in the middle of WAIT, then a key coinciding with reset release.
        keys('{15, 2, 10, 3});
        chk_en = 0;
        @(negedge clock);
        key_valid = 1'b1; key_code = 5'd14;
        @(posedge clock); #1;
        key_valid = 1'b0;
        exp_strobe++;
        @(posedge clock); #2;
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_mode", int'(disp_mode), 0);
        chk("midrst_strobe", int'(alu_strobe), 0);
        chk("midrst_value", int'(disp_value), 0);
        @(negedge clock);
        key_valid = 1'b1; key_code = 5'd5; reset = 1'b0;
        @(posedge clock); #1;
        key_valid = 1'b0;
        chk("release_key_ignored", int'(alu_a), 0);
        chk("release_mode", int'(disp_mode), 0);
        model_clear();
        chk_en = 1;
        repeat (3) @(posedge clock);
        #2;
        chk("no_capture_after_rst", int'(disp_mode), 0);
        chk("strobe_count", n_strobe, exp_strobe);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-to-ALU controller for the calculator datapath. Turns single-cycle key events into signed operands (±999) and an opcode, checks for divide-by-zero, and pulses the ALU compute strobe. It then captures the quotient/product/sum plus remainder and drives the display-side outputs. It sits between the key debouncer/decoder and the `alu` instance, and owns all sequencing of that datapath.

## Interface
- `MAX_MAG`, 999: largest operand magnitude accepted during entry.
- `ALU_LAT`, 1: cycles after the strobe-sampling edge before `alu_result` is valid.
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `key_valid`  in  1: one-cycle pulse; `key_code` is valid when this is high.
- `key_code`  in  5: 0–9 digit; 10 `+`; 11 `-`; 12 `*`; 13 `/`; 14 `=`; 15 clear; 16 negate; other values ignored.
- `alu_a`, `alu_b`  out  11: signed two's-complement operands, held stable from the strobe until capture.
- `alu_opcode`  out  2: 00 add, 01 sub, 10 mul, 11 div.
- `alu_strobe`  out  1: ALU compute enable, high for exactly 1 cycle per operation.
- `alu_result`  in  21: signed result from the ALU.
- `alu_remain`  in  1: remainder-nonzero flag from the ALU.
- `alu_remainder`  in  21: remainder magnitude from the ALU.
- `disp_value`  out  21: signed value to show.
- `disp_remain`  out  1: show remainder indicator.
- `disp_remainder`  out  21: remainder to show.
- `disp_mode`  out  2: 0 entering A; 1 entering B; 2 result; 3 error.
- `busy`  out  1: high in STROBE, WAIT and CAPTURE.

## Operation
**States:** ENTER_A, ENTER_B, STROBE, WAIT, CAPTURE, SHOW, ERROR. Reset state is ENTER_A.

**Operand storage**
- Each operand is held as a 10-bit magnitude plus a sign bit.
- `alu_a`/`alu_b` = sign ? −mag : mag.

**Digit key (ENTER_A/ENTER_B)**
- new = mag·10 + d, computed as (mag<<3)+(mag<<1)+d at 14-bit width.
- If new > `MAX_MAG`, the digit is dropped and the operand is unchanged.
- Sets the operand's `has_digit` flag.

**Negate key:** toggles the current operand's sign. Negating a zero magnitude leaves the sign at +.

**Operator keys**
- In ENTER_A: latch the opcode, clear B → ENTER_B.
- In ENTER_B with `has_digit`=0: replace the opcode.
- In ENTER_B with `has_digit`=1: ignored.

**`=` key**
- Ignored in ENTER_A, and in ENTER_B without a digit.
- In ENTER_B: if the opcode is div and B==0 → ERROR, with no strobe issued. Otherwise → STROBE.

**STROBE:** `alu_strobe`=1 for one cycle → WAIT.

**WAIT:** counts `ALU_LAT` cycles → CAPTURE.

**CAPTURE:** registers `alu_result`, `alu_remain`, `alu_remainder` into the display registers → SHOW.
- The remainder is displayed only for div; for other ops `disp_remain`=0.

**SHOW**
- Digit key: clear A, apply the digit → ENTER_A.
- Operator key: if |result| ≤ `MAX_MAG`, load the result into A (chaining), latch the opcode → ENTER_B; otherwise → ERROR.
- `=` and negate keys: ignored.

**ERROR:** `disp_mode`=3, `disp_value`=0. Only clear exits.

**Clear key:** from any non-busy state, zero everything → ENTER_A.

**While busy:** all keys, including clear, are ignored (dropped, not queued).

**`disp_value` by state:** the A operand in ENTER_A; B in ENTER_B; the captured result in SHOW.

## Timing
- **Reset values:** all outputs 0; state ENTER_A; `alu_opcode`=00.
- **Key latency:** a key sampled at edge k updates state and outputs at edge k (registered); they are visible in cycle k+1.
- **Strobe timing:** `=` at edge k → `alu_strobe` high in cycle k+1 → ALU samples at edge k+2.
- **Capture timing:** capture occurs at edge k+2+`ALU_LAT` → `disp_mode`=2 one cycle later. With the default, the result appears 4 cycles after `=`.
- **Operand stability:** `alu_a`, `alu_b`, `alu_opcode` do not change from STROBE through CAPTURE.
- **Reset mid-operation:** asynchronous reset during WAIT aborts immediately. No capture occurs and `alu_strobe` drops at once.
- **Simultaneous events:** a `key_valid` arriving in the same cycle reset deasserts is ignored.

## Structure
- **Package `calc_pkg`:**
  - key code constants
  - opcode constants (00/01/10/11, matching the ALU)
  - state enum
  - default `MAX_MAG`
- **Sub-module `operand_accum`:** holds one operand. It covers magnitude, sign, `has_digit`, digit-append with saturation, negate, clear, and load-from-result, and outputs an 11-bit two's-complement value. It is instantiated twice (A, B).
- **FSM and capture registers:** in `calc_sequencer`.

## Test plan
- Keys 1,2,3,+,4,5,= → `alu_strobe` pulses once with a=123, b=45, op=00; 4 cycles after `=`, `disp_value`=168, `disp_mode`=2.
- Keys 9,9,9,9 → A stays 999 (4th digit dropped); then negate → `alu_a`=−999 (11'h419).
- Keys 7,/,0,= → ERROR (`disp_mode`=3), no strobe; then clear → ENTER_A, all display outputs 0.
- Keys 7,negate,/,2,= → ALU returns −4 with remainder 1 → `disp_value`=−4, `disp_remain`=1, `disp_remainder`=1.
- Chaining and overflow:
  - Keys 5,*,6,=,+,4,= → second strobe with a=30, b=4 → 34.
  - Keys 999,*,999,=,+ → ERROR, because 998001 > `MAX_MAG`.
- Reset asserted during WAIT → `busy`=0, `disp_mode`=0 and `alu_strobe`=0 immediately, with no capture; keys during busy cycles produce no state change.
